// File: rtl/sel_rr_arbiter.sv
// sel_rr_arbiter: three-source round-robin arbiter driving the one-hot select lines of the
// 8-bit three-input selector downstream. One source is granted at a time. A grant ends on
// owner release, on hold-limit expiry or when the owner drops its request. When it ends, the
// arbiter re-arbitrates with the old owner at lowest priority.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   reqA/B/C  in   level-sensitive requests
//   rel       in   current owner finished (the name `release` is a reserved word); GRANT only
//   selA/B/C  out  registered selects, one-hot or all-zero
//   owner     out  registered owner code: 0 none, 1 A, 2 B, 3 C
//   hold_cnt  out  cycles elapsed in the current grant, starting at 0
module sel_rr_arbiter #(
  parameter int unsigned HOLD = 4,  // max grant length, 1..15
  parameter int unsigned CW   = 4   // hold counter width, 2^CW > HOLD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reqA,
  input  logic          reqB,
  input  logic          reqC,
  input  logic          rel,
  output logic          selA,
  output logic          selB,
  output logic          selC,
  output logic [1:0]    owner,
  output logic [CW-1:0] hold_cnt
);

  typedef enum logic [0:0] {StIdle, StGrant} stateE;

  stateE         stateQ, stateD;
  logic [1:0]    lastQ, lastD;
  logic [1:0]    ownerQ, ownerD;
  logic [2:0]    selQ, selD;      // {C, B, A}
  logic [CW-1:0] cntQ, cntD;

  logic [1:0]    winner;
  logic          ownerReq;
  logic          grantEnd;

  function automatic logic [2:0] decodeSel(input logic [1:0] code);
    logic [2:0] s;
    case (code)
      2'd1:    s = 3'b001;
      2'd2:    s = 3'b010;
      2'd3:    s = 3'b100;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

  // Search starts at the source after lastQ, cyclic A->B->C->A.
  always_comb begin
    winner = 2'd0;
    case (lastQ)
      2'd1: begin
        if (reqB)      winner = 2'd2;
        else if (reqC) winner = 2'd3;
        else if (reqA) winner = 2'd1;
      end
      2'd2: begin
        if (reqC)      winner = 2'd3;
        else if (reqA) winner = 2'd1;
        else if (reqB) winner = 2'd2;
      end
      default: begin
        if (reqA)      winner = 2'd1;
        else if (reqB) winner = 2'd2;
        else if (reqC) winner = 2'd3;
      end
    endcase
  end

  always_comb begin
    ownerReq = 1'b0;
    case (ownerQ)
      2'd1:    ownerReq = reqA;
      2'd2:    ownerReq = reqB;
      2'd3:    ownerReq = reqC;
      default: ownerReq = 1'b0;
    endcase
  end

  // All end conditions fold into one event so the pointer advances at most once.
  assign grantEnd = rel | (cntQ == CW'(HOLD - 1)) | ~ownerReq;

  always_comb begin
    stateD = stateQ;
    lastD  = lastQ;
    ownerD = ownerQ;
    selD   = selQ;
    cntD   = cntQ;
    case (stateQ)
      StIdle: begin
        if (winner != 2'd0) begin
          stateD = StGrant;
          ownerD = winner;
          lastD  = winner;
          selD   = decodeSel(winner);
          cntD   = '0;
        end
      end
      StGrant: begin
        if (!grantEnd) begin
          cntD = cntQ + CW'(1);
        end else if (winner != 2'd0) begin
          // Direct hand-over, no idle gap; lastQ equals the old owner here.
          ownerD = winner;
          lastD  = winner;
          selD   = decodeSel(winner);
          cntD   = '0;
        end else begin
          stateD = StIdle;
          ownerD = 2'd0;
          selD   = 3'b000;
          cntD   = '0;
        end
      end
      default: begin
        stateD = StIdle;
        ownerD = 2'd0;
        selD   = 3'b000;
        cntD   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
      lastQ  <= 2'd3;
      ownerQ <= 2'd0;
      selQ   <= 3'b000;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      lastQ  <= lastD;
      ownerQ <= ownerD;
      selQ   <= selD;
      cntQ   <= cntD;
    end
  end

  assign selA     = selQ[0];
  assign selB     = selQ[1];
  assign selC     = selQ[2];
  assign owner    = ownerQ;
  assign hold_cnt = cntQ;

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Bench for sel_rr_arbiter: a behavioural round-robin model checked on every cycle, plus
// directed sequences with literal expectations.
module tb_sel_rr_arbiter;
  localparam int unsigned HOLD = 4;
  localparam int unsigned CW   = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          reqA  = 1'b0;
  logic          reqB  = 1'b0;
  logic          reqC  = 1'b0;
  logic          rel   = 1'b0;
  logic          selA, selB, selC;
  logic [1:0]    owner;
  logic [CW-1:0] hold_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: owner 0..3, cycles into grant, pointer 1..3, per-source wait counters.
  int mOwner = 0;
  int mCnt   = 0;
  int mLast  = 3;
  int waitCnt [3] = '{0, 0, 0};

  sel_rr_arbiter #(.HOLD(HOLD), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reqA     (reqA),
    .reqB     (reqB),
    .reqC     (reqC),
    .rel      (rel),
    .selA     (selA),
    .selB     (selB),
    .selC     (selC),
    .owner    (owner),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rrPick(input int last, input logic [2:0] r);
    int cand;
    for (int k = 1; k <= 3; k++) begin
      cand = (last + k - 1) % 3 + 1;
      if (r[cand-1]) return cand;
    end
    return 0;
  endfunction

  // Behavioural model, advanced on each rising edge.
  always @(posedge clk or negedge rst_n) begin : model
    int nO, nC, nL, w;
    logic [2:0] r;
    if (!rst_n) begin
      mOwner <= 0;
      mCnt   <= 0;
      mLast  <= 3;
      for (int i = 0; i < 3; i++) waitCnt[i] <= 0;
    end else begin
      r  = {reqC, reqB, reqA};
      nO = mOwner;
      nC = mCnt;
      nL = mLast;
      if (mOwner == 0 || rel || mCnt == HOLD - 1 || !r[mOwner-1]) begin
        w = rrPick(mLast, r);
        nO = w;
        nC = 0;
        if (w != 0) nL = w;
      end else begin
        nC = mCnt + 1;
      end
      mOwner <= nO;
      mCnt   <= nC;
      mLast  <= nL;
      for (int i = 0; i < 3; i++) begin
        if (r[i] && nO != i + 1) begin
          waitCnt[i] <= waitCnt[i] + 1;
          check("starvation", int'(waitCnt[i] + 1 > 2 * HOLD), 0);
        end else begin
          waitCnt[i] <= 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("selA", int'(selA), int'(mOwner == 1));
    check("selB", int'(selB), int'(mOwner == 2));
    check("selC", int'(selC), int'(mOwner == 3));
    check("owner", int'(owner), mOwner);
    check("hold_cnt", int'(hold_cnt), mCnt);
    check("onehot", int'($countones({selC, selB, selA}) <= 1), 1);
  end

  task automatic expectOut(input string tag, input int eo, input int ec);
    int es;
    es = (eo == 0) ? 0 : (1 << (eo - 1));
    check({tag, " owner"}, int'(owner), eo);
    check({tag, " hold_cnt"}, int'(hold_cnt), ec);
    check({tag, " sels"}, int'({selC, selB, selA}), es);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    reqA  = 1'b0;
    reqB  = 1'b0;
    reqC  = 1'b0;
    rel   = 1'b0;
    @(negedge clk);
  endtask

  int rotOwn [13] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1};

  initial begin
    repeat (2) @(negedge clk);
    expectOut("reset", 0, 0);

    // All three requesting: A, B, C four cycles each, then A again.
    reqA = 1'b1; reqB = 1'b1; reqC = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      expectOut("rotate", rotOwn[i], i % 4);
    end

    // Lone requester B keeps its select through hold expiry.
    doReset();
    reqB = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expectOut("onlyB", 2, i % 4);
    end

    // Early release by A at hold_cnt 1 hands over to C.
    doReset();
    reqA = 1'b1; reqC = 1'b1;
    rst_n = 1'b1;
    @(negedge clk); expectOut("relA0", 1, 0);
    @(negedge clk); expectOut("relA1", 1, 1);
    rel = 1'b1;
    @(negedge clk); expectOut("relC0", 3, 0);
    rel = 1'b0; reqA = 1'b0; reqC = 1'b0;
    @(negedge clk); expectOut("relIdle", 0, 0);

    // Owner A drops its request at hold_cnt 2 with nobody else waiting.
    doReset();
    reqA = 1'b1;
    rst_n = 1'b1;
    @(negedge clk); expectOut("dropA0", 1, 0);
    @(negedge clk); expectOut("dropA1", 1, 1);
    @(negedge clk); expectOut("dropA2", 1, 2);
    reqA = 1'b0;
    @(negedge clk); expectOut("dropIdle", 0, 0);

    // From idle with pointer at A, B is granted; then an asynchronous reset mid-grant.
    reqB = 1'b1;
    @(negedge clk); expectOut("grantB0", 2, 0);
    @(negedge clk); expectOut("grantB1", 2, 1);
    #2 rst_n = 1'b0;
    #1 expectOut("asyncRst", 0, 0);
    reqA = 1'b1; reqB = 1'b1; reqC = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); expectOut("postRst", 1, 0);

    // Random requests and release; the per-cycle model compare does the checking.
    doReset();
    rst_n = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 9) == 0) reqA = ~reqA;
      if ($urandom_range(0, 9) == 0) reqB = ~reqB;
      if ($urandom_range(0, 9) == 0) reqC = ~reqC;
      rel = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
